// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared ALU types and arbiter limits.
package cpu_types_pkg;
    localparam int ARB_MAX_REQ = 4;
    typedef logic [31:0] word_t;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;
    typedef struct packed {
        aluop_t op;
        word_t  a;
        word_t  b;
    } alu_req_t;
endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: operand/result bus between the arbiter (master) and the shared ALU (slave).
interface alu_share_arb_if;
    import cpu_types_pkg::*;
    aluop_t op;
    word_t  pa;
    word_t  pb;
    word_t  presult;
    logic   neg;
    logic   ovf;
    logic   zero;
    modport master (output op, pa, pb, input presult, neg, ovf, zero);
    modport slave  (input op, pa, pb, output presult, neg, ovf, zero);
endinterface

// File: rtl/alu_share_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first eligible at or above ptr with wrap.
module rr_pick #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    int j;
    logic [W-1:0] jw;
    // Walk from the lowest priority down so the highest-priority hit is written last.
    always_comb begin
        gnt = '0;
        idx = '0;
        j = 0;
        jw = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            jw = W'(j);
            if (eligible[jw]) begin
                gnt = '0;
                gnt[jw] = 1'b1;
                idx = jw;
            end
        end
    end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational ALU among NREQ requesters,
// with a grant stage, an execute stage and per-requester result registers.
module alu_share_arb
    import cpu_types_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0][3:0]   req_op,
    input  word_t [NREQ-1:0]       req_a,
    input  word_t [NREQ-1:0]       req_b,
    input  logic                   flush,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output word_t [NREQ-1:0]       res,
    output logic [NREQ-1:0]        res_neg,
    output logic [NREQ-1:0]        res_ovf,
    output logic [NREQ-1:0]        res_zero,
    alu_share_arb_if.master        alu
);
    localparam int PW = $clog2(NREQ);
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] pick;
    logic            b_valid;
    logic [PW-1:0]   b_owner;
    alu_req_t        b_req;
    // A requester with an op still executing must wait, giving one outstanding op each.
    for (genvar i = 0; i < NREQ; i++) begin : g_elig
        assign elig[i] = req[i] && !(b_valid && b_owner == PW'(i));
    end
    rr_pick #(.N(NREQ), .W(PW)) u_pick (
        .eligible (elig),
        .ptr      (ptr),
        .gnt      (pick),
        .idx      (win)
    );
    assign gnt    = nRST ? pick : '0;
    assign alu.op = b_valid ? b_req.op : aluop_t'(4'd0);
    assign alu.pa = b_valid ? b_req.a : '0;
    assign alu.pb = b_valid ? b_req.b : '0;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr      <= '0;
            b_valid  <= 1'b0;
            b_owner  <= '0;
            b_req    <= '0;
            done     <= '0;
            res      <= '0;
            res_neg  <= '0;
            res_ovf  <= '0;
            res_zero <= '0;
        end else begin
            b_valid <= |pick;
            if (|pick) begin
                b_owner <= win;
                b_req   <= '{op: aluop_t'(req_op[win]), a: req_a[win], b: req_b[win]};
                ptr     <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
            end
            done <= '0;
            if (b_valid && !flush) begin
                done[b_owner]     <= 1'b1;
                res[b_owner]      <= alu.presult;
                res_neg[b_owner]  <= alu.neg;
                res_ovf[b_owner]  <= alu.ovf;
                res_zero[b_owner] <= alu.zero;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed and random checks of alu_share_arb against a transaction-level model.
module tb_alu_share_arb;
    import cpu_types_pkg::*;
    localparam int N = 2;
    logic              CLK = 1'b0;
    logic              nRST;
    logic [N-1:0]      req;
    logic [N-1:0][3:0] req_op;
    word_t [N-1:0]     req_a;
    word_t [N-1:0]     req_b;
    logic              flush;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    word_t [N-1:0]     res;
    logic [N-1:0]      res_neg;
    logic [N-1:0]      res_ovf;
    logic [N-1:0]      res_zero;
    int checks = 0;
    int errors = 0;
    alu_share_arb_if alu_bus ();
    alu_share_arb #(.NREQ(N)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .req      (req),
        .req_op   (req_op),
        .req_a    (req_a),
        .req_b    (req_b),
        .flush    (flush),
        .gnt      (gnt),
        .done     (done),
        .res      (res),
        .res_neg  (res_neg),
        .res_ovf  (res_ovf),
        .res_zero (res_zero),
        .alu      (alu_bus)
    );
    always #5 CLK = ~CLK;
    // Behavioural ALU: returns {neg, ovf, zero, result}.
    function automatic logic [34:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic o;
        o = 1'b0;
        case (op)
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_ADD:  begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB:  begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'd0, a < b};
            default:  r = 32'd0;
        endcase
        return {r[31], o, r == 32'd0, r};
    endfunction
    assign {alu_bus.neg, alu_bus.ovf, alu_bus.zero, alu_bus.presult} = alu_f(alu_bus.op, alu_bus.pa, alu_bus.pb);
    typedef struct {
        int          owner;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;
    op_t         inflight[$];
    int          ptr_m;
    logic [N-1:0] done_m;
    logic [31:0] res_m [N];
    logic        neg_m [N];
    logic        ovf_m [N];
    logic        zero_m [N];
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic bit busy(input int i);
        foreach (inflight[q]) if (inflight[q].owner == i) return 1'b1;
        return 1'b0;
    endfunction
    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        int i;
        g = '0;
        for (int k = 0; k < N; k++) begin
            i = (ptr_m + k) % N;
            if (g == '0 && req[i] && !busy(i)) g[i] = 1'b1;
        end
        return g;
    endfunction
    task automatic model_reset();
        inflight.delete();
        ptr_m = 0;
        done_m = '0;
        for (int i = 0; i < N; i++) begin
            res_m[i] = '0; neg_m[i] = 1'b0; ovf_m[i] = 1'b0; zero_m[i] = 1'b0;
        end
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_op"}, alu_bus.op, 0);
        check({tag, "_pa"}, alu_bus.pa, 0);
        check({tag, "_pb"}, alu_bus.pb, 0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_res%0d", tag, i), res[i], 0);
            check($sformatf("%s_flags%0d", tag, i), {res_neg[i], res_ovf[i], res_zero[i]}, 0);
        end
    endtask
    task automatic sample();
        @(negedge CLK);
        check("gnt", gnt, model_grant());
        check("done", done, done_m);
        check("alu_op", alu_bus.op, inflight.size() > 0 ? inflight[0].op : 4'd0);
        check("alu_pa", alu_bus.pa, inflight.size() > 0 ? inflight[0].a : 32'd0);
        check("alu_pb", alu_bus.pb, inflight.size() > 0 ? inflight[0].b : 32'd0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("res%0d", i), res[i], res_m[i]);
            check($sformatf("flags%0d", i), {res_neg[i], res_ovf[i], res_zero[i]}, {neg_m[i], ovf_m[i], zero_m[i]});
        end
    endtask
    task automatic advance();
        logic [N-1:0] g;
        logic [34:0] f;
        op_t o;
        g = model_grant();
        done_m = '0;
        if (inflight.size() > 0) begin
            o = inflight.pop_front();
            if (!flush) begin
                f = alu_f(o.op, o.a, o.b);
                {neg_m[o.owner], ovf_m[o.owner], zero_m[o.owner], res_m[o.owner]} = f;
                done_m[o.owner] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                inflight.push_back('{owner: i, op: req_op[i], a: req_a[i], b: req_b[i]});
                ptr_m = (i + 1) % N;
            end
        end
        @(posedge CLK);
        #1;
    endtask
    task automatic step();
        sample();
        advance();
    endtask
    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        nRST = 1'b1;
        req = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        flush = 1'b0;
        #2 nRST = 1'b0;
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check_zero("rst");
        nRST = 1'b1;
        // Single request: grant at t, ALU at t+1, done at t+2.
        req_op[0] = ALU_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7; req[0] = 1'b1;
        sample();
        check("single_gnt", gnt, 2'b01);
        advance();
        req = '0;
        sample();
        check("single_op", alu_bus.op, ALU_ADD);
        check("single_pa", alu_bus.pa, 32'd5);
        check("single_pb", alu_bus.pb, 32'd7);
        advance();
        sample();
        check("single_done", done, 2'b01);
        check("single_res", res[0], 32'd12);
        check("single_zero", res_zero[0], 1'b0);
        advance();
        // Reset while an op sits in execute.
        req_op[0] = ALU_SUB; req_a[0] = 32'd9; req_b[0] = 32'd4; req[0] = 1'b1;
        step();
        req = 2'b11;
        nRST = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        req = '0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("postrst_done", done, 2'b00);
            advance();
        end
        // Contention: both held, grants alternate starting with requester 0.
        req_op[0] = ALU_SUB; req_a[0] = 32'd3; req_b[0] = 32'd3;
        req_op[1] = ALU_ADD; req_a[1] = 32'h7FFF_FFFF; req_b[1] = 32'd1;
        req = 2'b11;
        for (int c = 0; c < 4; c++) begin
            sample();
            check("cont_gnt", gnt, (c % 2 == 0) ? 2'b01 : 2'b10);
            advance();
        end
        req = '0;
        step();
        step();
        sample();
        check("cont_res0", res[0], 32'd0);
        check("cont_zero0", res_zero[0], 1'b1);
        check("cont_res1", res[1], 32'h8000_0000);
        check("cont_negovf1", {res_neg[1], res_ovf[1]}, 2'b11);
        advance();
        // Fairness: r1 held, r0 pulses every 4 cycles and must win each pulse.
        req_op[0] = ALU_ADD; req_a[0] = 32'd1; req_b[0] = 32'd1;
        req_op[1] = ALU_OR;  req_a[1] = 32'hF0; req_b[1] = 32'h0F;
        for (int c = 0; c < 16; c++) begin
            req[1] = 1'b1;
            req[0] = (c % 4 == 0);
            sample();
            if (c % 4 == 0) check("fair_gnt0", gnt[0], 1'b1);
            advance();
        end
        req = '0;
        for (int c = 0; c < 3; c++) step();
        // Flush kills r0 in execute while r1 is granted.
        req_op[0] = ALU_ADD; req_a[0] = 32'd100; req_b[0] = 32'd100; req[0] = 1'b1;
        step();
        req = 2'b10;
        req_op[1] = ALU_XOR; req_a[1] = 32'hFF00; req_b[1] = 32'h0FF0;
        flush = 1'b1;
        sample();
        check("flush_gnt", gnt, 2'b10);
        advance();
        flush = 1'b0;
        req = '0;
        sample();
        check("flush_nodone", done, 2'b00);
        advance();
        sample();
        check("flush_r1done", done, 2'b10);
        check("flush_res0_kept", res[0], 32'd2);
        check("flush_res1", res[1], 32'h0000_F0F0);
        advance();
        // Idle: nothing moves, pointer must still favour requester 0.
        for (int c = 0; c < 10; c++) step();
        req = 2'b11;
        sample();
        check("idle_ptr_gnt", gnt, 2'b01);
        advance();
        req = '0;
        step();
        step();
        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            req = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_op[i] = 4'($urandom_range(0, 9));
                req_a[i] = rand_word();
                req_b[i] = rand_word();
            end
            flush = ($urandom_range(0, 7) == 0);
            step();
        end
        req = '0;
        flush = 1'b0;
        for (int c = 0; c < 4; c++) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single combinational ALU (alu_if, alu modport side) between NREQ requesters, e.g. the execute stage and a background address/compare engine.
- Round-robin arbitration feeds a 2-stage issue/execute pipeline.
- Operands are registered at grant and driven into the ALU the next cycle.
- Result and flags are captured into per-requester result registers, signalled by a done pulse.

Parameters:
- NREQ, 2, number of requesters (2..4).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- req  in  NREQ  request valid, one bit per requester.
- req_op  in  NREQ x 4  aluop_t per requester.
- req_a  in  NREQ x 32  word_t operand A per requester.
- req_b  in  NREQ x 32  word_t operand B per requester.
- flush  in  1  synchronous kill of the op currently in execute.
- gnt  out  NREQ  one-hot, one-cycle grant pulse.
- done  out  NREQ  one-hot, one-cycle completion pulse.
- res  out  NREQ x 32  per-requester result register.
- res_neg, res_ovf, res_zero  out  NREQ each  per-requester flag registers.
- alu_op  out  4  to ALU alu_op.
- alu_pa, alu_pb  out  32 each  to ALU pa/pb.
- alu_presult  in  32  from ALU presult.
- alu_neg, alu_ovf, alu_zero  in  1 each  from ALU.

Behaviour:
- Reset (async, nRST=0), all cleared:
  - gnt, done, res*, flag registers = 0.
  - Stage-B valid = 0.
  - Round-robin pointer = 0 (requester 0 has highest priority first).
  - alu_op/alu_pa/alu_pb = 0.
- Eligibility: requester i is eligible when req[i]=1 and it has no op in stage B (at most one outstanding op per requester).
- Grant (stage A, combinational, registered pulse):
  - Among eligible requesters, search from ptr upward with wrap; first hit wins.
  - gnt[i] is asserted in the same cycle, combinational from req and state.
  - At that edge, req_op/a/b[i] are latched into stage B with owner=i, valid=1.
  - ptr becomes (i+1) mod NREQ.
  - With no eligible requester: no grant, ptr unchanged, stage-B valid=0 next cycle.
- Requester rules: hold req and operands stable until it sees gnt; deassert or present a new op in the cycle after gnt. A req dropped before gnt is simply never served.
- Execute (stage B):
  - When valid, alu_op/pa/pb = stage-B registers; otherwise drive 0.
  - At the edge ending stage B, if valid and not flush: res[owner] <= alu_presult, flags[owner] <= ALU flags, done[owner] <= 1 for one cycle.
- Latency: grant cycle t, ALU evaluates in t+1, done and valid res visible in t+2.
- Throughput: one op per cycle total. A single requester can issue every other cycle; two requesters interleave back-to-back.
- Result registers hold until the next done for the same requester. Other requesters' registers are never disturbed.
- flush: only the stage-B op is dropped (no done, no result write). A grant in the same cycle still proceeds. The flushed requester becomes eligible again next cycle.
- Simultaneous grant and completion for the same requester is impossible by the eligibility rule.
- nRST low mid-operation discards everything; no done is issued after reset release.

Decomposition:
- Shared package cpu_types_pkg:
  - alu_req_t struct {aluop_t op; word_t a; word_t b;}
  - ARB_MAX_REQ = 4.
- Sub-module rr_pick: combinational round-robin picker; inputs eligible vector and ptr; outputs one-hot grant and winner index. Reusable by the memory arbiter.
- Stage registers and result bank stay in alu_share_arb.

Test Plan:
- Reset: nRST=0 mid-stream with an op in stage B → all outputs 0 and no done after release; first grant goes to requester 0 when both request.
- Single request: req[0]=1, ALU_ADD, a=5, b=7, at cycle t → gnt[0] at t; alu_op=ALU_ADD with pa=5, pb=7 at t+1; done[0] at t+2 with res[0]=12, zero=0.
- Contention: both req held, r0 ALU_SUB 3-3, r1 ALU_ADD 0x7FFFFFFF+1 → grants r0, r1, r0, r1 on consecutive cycles; r0 result 0 with zero=1; r1 result 0x80000000 with neg=1, ovf=1.
- Fairness: r1 held continuously, r0 pulses every 4 cycles → r0 granted in the first cycle it is eligible; no requester waits more than NREQ cycles.
- flush: flush=1 in the execute cycle of an r0 op while r1 is granted → no done[0], res[0] keeps its old value; r1 completes normally.
- Idle: no req for 10 cycles → gnt=0, done=0, ALU inputs 0, ptr unchanged.
